fetch_unit: RTL

Instruction-fetch stage with integrated IF/ID pipeline register. It sits directly upstream of the control decoder and feeds it.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Presents one fetched instruction per cycle to the decode stage, with its PC and a valid flag; `op_o` drives the decoder opcode input directly.
- Handles decode-stage back-pressure (stall) and control-flow redirects (flush).

---
 rtl/fetch_unit_pkg.sv | 17 +
 rtl/fetch_unit_if_id_reg.sv | 53 +++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared opcode constants and fetch FSM encodings
package fetch_unit_pkg;

    localparam int OPCODE_W = 7;

    localparam logic [OPCODE_W-1:0] OP_OPIMM = 7'h13;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = {25'h0, OP_OPIMM};

    typedef enum logic [1:0] {
        FS_FETCH = 2'b00,
        FS_HOLD  = 2'b01,
        FS_DRAIN = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with load/bubble/hold controls
module fetch_unit_if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic                bubble_i,
    input  logic [31:0]         instr_i,
    input  logic [31:0]         pc_i,
    output logic [31:0]         instr_o,
    output logic [31:0]         pc_o,
    output logic                valid_o,
    output logic [OPCODE_W-1:0] op_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    // Bubble wins over load; the PC is left alone on a bubble since valid_o marks it stale.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (bubble_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_q <= NOP_INSTR;
            pc_q    <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;
    assign op_o    = instr_q[OPCODE_W-1:0];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, stall buffer, redirect drain
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    output logic                imem_req_o,
    output logic [31:0]         imem_addr_o,
    input  logic                imem_ack_i,
    input  logic [31:0]         imem_rdata_i,
    output logic [31:0]         instr_o,
    output logic [31:0]         pc_o,
    output logic                valid_o,
    output logic [OPCODE_W-1:0] op_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  buf_pc_q, buf_pc_d;

    logic         ifid_load;
    logic         ifid_bubble;
    logic [31:0]  ifid_instr;
    logic [31:0]  ifid_pc;

    logic         unused_rpc_lsb;
    assign unused_rpc_lsb = ^redirect_pc_i[1:0];

    // In DRAIN pc_q already holds the redirect target, so the stale address is kept separately.
    assign imem_req_o  = !rst_i && (state_q != FS_HOLD);
    assign imem_addr_o = rst_i ? RESET_PC :
                         (state_q == FS_DRAIN) ? drain_addr_q : pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_instr   = imem_rdata_i;
        ifid_pc      = pc_q;

        if (redirect_i) begin
            ifid_bubble = 1'b1;
            pc_d        = {redirect_pc_i[31:2], 2'b00};
            buf_instr_d = NOP_INSTR;
            buf_pc_d    = 32'h0;
            if ((state_q != FS_HOLD) && !imem_ack_i) begin
                state_d = FS_DRAIN;
                if (state_q == FS_FETCH) begin
                    drain_addr_d = pc_q;
                end
            end else begin
                state_d = FS_FETCH;
            end
        end else begin
            case (state_q)
                FS_FETCH: begin
                    if (imem_ack_i) begin
                        pc_d = pc_q + 32'd4;
                        if (stall_i) begin
                            buf_instr_d = imem_rdata_i;
                            buf_pc_d    = pc_q;
                            state_d     = FS_HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!stall_i) begin
                        ifid_bubble = 1'b1;
                    end
                end
                FS_HOLD: begin
                    if (!stall_i) begin
                        ifid_load  = 1'b1;
                        ifid_instr = buf_instr_q;
                        ifid_pc    = buf_pc_q;
                        state_d    = FS_FETCH;
                    end
                end
                FS_DRAIN: begin
                    if (imem_ack_i) begin
                        state_d = FS_FETCH;
                    end
                    if (!stall_i) begin
                        ifid_bubble = 1'b1;
                    end
                end
                default: state_d = FS_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= FS_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            buf_instr_q  <= NOP_INSTR;
            buf_pc_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
        end
    end

    fetch_unit_if_id_reg u_if_id (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .instr_i  (ifid_instr),
        .pc_i     (ifid_pc),
        .instr_o  (instr_o),
        .pc_o     (pc_o),
        .valid_o  (valid_o),
        .op_o     (op_o)
    );

endmodule
